// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer with saturating direction counters.
//   It gives fetch a same-cycle taken/target prediction, and MEM writes back
//   the resolved outcome of each conditional branch.
//   MODE=0 indexes by PC only (bimodal). MODE=1 XORs the index with a
//   non-speculative global history register (gshare).
//
// Ports
//   CLK              in   clock, all state changes on the rising edge
//   RST              in   synchronous active-high reset
//   fetch_pc         in   PC being fetched
//   pred_hit         out  valid entry with matching tag (combinational)
//   pred_taken       out  pred_hit and counter MSB set
//   pred_target      out  stored target on a hit, else 0
//   lookup_ghr       out  history used for this lookup (0 in MODE=0)
//   upd_en           in   resolved branch in MEM this cycle
//   upd_pc           in   PC of the resolved branch
//   upd_taken        in   actual direction
//   upd_target       in   actual target
//   upd_ghr          in   lookup_ghr snapshot carried with the branch
//   upd_mispredict   in   pipeline saw a wrong prediction for this branch
//   stat_updates     out  saturating count of upd_en cycles
//   stat_mispredicts out  saturating count of upd_en && upd_mispredict cycles
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int MODE    = 0,
    parameter int GHR_W   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      fetch_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [GHR_W-1:0] lookup_ghr,
    input  logic             upd_en,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_mispredict,
    output logic [31:0]      stat_updates,
    output logic [31:0]      stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};

    // Table storage
    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];

    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [31:0]      stat_upd_q, stat_upd_d;
    logic [31:0]      stat_mis_q, stat_mis_d;

    // Word-aligned PC bits never select an entry.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

    function automatic logic [IDX_W-1:0] calc_idx(input logic [31:0] pc,
                                                  input logic [GHR_W-1:0] hist);
        logic [IDX_W-1:0] idx;
        idx = pc[IDX_W+1:2];
        if (MODE == 1) begin
            idx = idx ^ IDX_W'(hist);
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [31:0] stat_inc(input logic [31:0] s);
        return (s == 32'hFFFF_FFFF) ? s : s + 32'd1;
    endfunction

    // Lookup: purely combinational, reads pre-update contents (no bypass).
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;

    assign lk_idx      = calc_idx(fetch_pc, ghr_q);
    assign lk_tag      = fetch_pc[31:IDX_W+2];
    assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
    assign pred_target = pred_hit ? tgt_q[lk_idx] : 32'd0;
    assign lookup_ghr  = ghr_q;

    // Update decode: one entry at most is written per cycle.
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             ent_we;
    logic             ent_valid_d;
    logic [TAG_W-1:0] ent_tag_d;
    logic [31:0]      ent_tgt_d;
    logic [CNT_W-1:0] ent_cnt_d;

    assign up_idx = calc_idx(upd_pc, upd_ghr);
    assign up_tag = upd_pc[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        ent_we      = 1'b0;
        ent_valid_d = valid_q[up_idx];
        ent_tag_d   = tag_q[up_idx];
        ent_tgt_d   = tgt_q[up_idx];
        ent_cnt_d   = cnt_q[up_idx];
        ghr_d       = ghr_q;
        stat_upd_d  = stat_upd_q;
        stat_mis_d  = stat_mis_q;

        if (upd_en) begin
            stat_upd_d = stat_inc(stat_upd_q);
            if (upd_mispredict) begin
                stat_mis_d = stat_inc(stat_mis_q);
            end
            // History is only ever advanced by resolved branches.
            if (MODE == 1) begin
                ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
            end

            if (up_hit) begin
                ent_we = 1'b1;
                if (upd_taken) begin
                    ent_cnt_d = cnt_inc(cnt_q[up_idx]);
                    ent_tgt_d = upd_target;
                end else begin
                    ent_cnt_d = cnt_dec(cnt_q[up_idx]);
                end
            end else if (upd_taken) begin
                // Only taken branches earn a slot; a not-taken miss leaves it alone.
                ent_we      = 1'b1;
                ent_valid_d = 1'b1;
                ent_tag_d   = up_tag;
                ent_tgt_d   = upd_target;
                ent_cnt_d   = CNT_WT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= CNT_WNT;
            end
            ghr_q      <= '0;
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (ent_we) begin
                valid_q[up_idx] <= ent_valid_d;
                tag_q[up_idx]   <= ent_tag_d;
                tgt_q[up_idx]   <= ent_tgt_d;
                cnt_q[up_idx]   <= ent_cnt_d;
            end
            ghr_q      <= ghr_d;
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_updates     = stat_upd_q;
    assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Two predictors side by side: u_bim (MODE=0) and u_gsh (MODE=1, GHR_W=4).
//   Directed stimulus pushes hand-computed expectations into a queue; a
//   monitor on the falling edge pops and compares them against the DUTs.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // bimodal instance signals
    logic        rst0 = 1'b1;
    logic [31:0] f0 = '0;
    logic        hit0, tkn0;
    logic [31:0] tgt0;
    logic [3:0]  lg0;
    logic        ue0 = 1'b0, ut0 = 1'b0, um0 = 1'b0;
    logic [31:0] up0 = '0, utg0 = '0;
    logic [3:0]  ug0 = '0;
    logic [31:0] su0, sm0;

    // gshare instance signals
    logic        rst1 = 1'b1;
    logic [31:0] f1 = '0;
    logic        hit1, tkn1;
    logic [31:0] tgt1;
    logic [3:0]  lg1;
    logic        ue1 = 1'b0, ut1 = 1'b0, um1 = 1'b0;
    logic [31:0] up1 = '0, utg1 = '0;
    logic [3:0]  ug1 = '0;
    logic [31:0] su1, sm1;

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .MODE(0), .GHR_W(4)) u_bim (
        .CLK(CLK), .RST(rst0), .fetch_pc(f0),
        .pred_hit(hit0), .pred_taken(tkn0), .pred_target(tgt0), .lookup_ghr(lg0),
        .upd_en(ue0), .upd_pc(up0), .upd_taken(ut0), .upd_target(utg0),
        .upd_ghr(ug0), .upd_mispredict(um0),
        .stat_updates(su0), .stat_mispredicts(sm0)
    );

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .MODE(1), .GHR_W(4)) u_gsh (
        .CLK(CLK), .RST(rst1), .fetch_pc(f1),
        .pred_hit(hit1), .pred_taken(tkn1), .pred_target(tgt1), .lookup_ghr(lg1),
        .upd_en(ue1), .upd_pc(up1), .upd_taken(ut1), .upd_target(utg1),
        .upd_ghr(ug1), .upd_mispredict(um1),
        .stat_updates(su1), .stat_mispredicts(sm1)
    );

    // Signal selectors for expectations
    localparam int S_HIT0 = 0, S_TKN0 = 1, S_TGT0 = 2, S_SU0 = 3, S_SM0 = 4, S_LG0 = 5;
    localparam int S_HIT1 = 10, S_TKN1 = 11, S_TGT1 = 12, S_SU1 = 13, S_SM1 = 14, S_LG1 = 15;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] getval(input int sel);
        case (sel)
            S_HIT0:  return {31'd0, hit0};
            S_TKN0:  return {31'd0, tkn0};
            S_TGT0:  return tgt0;
            S_SU0:   return su0;
            S_SM0:   return sm0;
            S_LG0:   return {28'd0, lg0};
            S_HIT1:  return {31'd0, hit1};
            S_TKN1:  return {31'd0, tkn1};
            S_TGT1:  return tgt1;
            S_SU1:   return su1;
            S_SM1:   return sm1;
            S_LG1:   return {28'd0, lg1};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: everything queued during a cycle is compared at its falling edge.
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = q.pop_front();
            act = getval(e.sel);
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        q.push_back('{name, sel, v});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd0(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        ue0 = 1'b1; up0 = pc; ut0 = t; utg0 = tg;
        tick();
        ue0 = 1'b0;
    endtask

    task automatic upd1(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                        input logic [3:0] g, input logic m);
        ue1 = 1'b1; up1 = pc; ut1 = t; utg1 = tg; ug1 = g; um1 = m;
        tick();
        ue1 = 1'b0; um1 = 1'b0;
    endtask

    initial begin
        // Cold start
        tick();
        tick();
        rst0 = 1'b0;
        rst1 = 1'b0;
        f0 = 32'h40;
        expect_v("cold_hit",   S_HIT0, 32'd0);
        expect_v("cold_taken", S_TKN0, 32'd0);
        expect_v("cold_tgt",   S_TGT0, 32'd0);
        expect_v("cold_supd",  S_SU0,  32'd0);
        expect_v("cold_smis",  S_SM0,  32'd0);
        expect_v("cold_ghr",   S_LG0,  32'd0);
        expect_v("cold_ghr_g", S_LG1,  32'd0);
        tick();

        // Allocation
        upd0(32'h40, 1'b1, 32'h100);
        expect_v("alloc_hit",   S_HIT0, 32'd1);
        expect_v("alloc_taken", S_TKN0, 32'd1);
        expect_v("alloc_tgt",   S_TGT0, 32'h100);
        expect_v("alloc_supd",  S_SU0,  32'd1);
        expect_v("bim_ghr_held", S_LG0, 32'd0);
        tick();

        // Counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10
        upd0(32'h40, 1'b0, 32'h0);
        expect_v("nt1_taken", S_TKN0, 32'd0);
        expect_v("nt1_hit",   S_HIT0, 32'd1);
        tick();
        upd0(32'h40, 1'b0, 32'h0);
        expect_v("nt2_taken", S_TKN0, 32'd0);
        tick();
        upd0(32'h40, 1'b0, 32'h0);
        expect_v("nt3_sat_taken", S_TKN0, 32'd0);
        expect_v("nt3_tgt_kept",  S_TGT0, 32'h100);
        tick();
        upd0(32'h40, 1'b1, 32'h100);
        expect_v("t1_taken", S_TKN0, 32'd0);
        tick();
        upd0(32'h40, 1'b1, 32'h100);
        expect_v("t2_taken", S_TKN0, 32'd1);
        expect_v("walk_supd", S_SU0, 32'd6);
        tick();

        // Aliasing at idx 0
        upd0(32'h80, 1'b0, 32'h200);
        expect_v("alias_nt_hit", S_HIT0, 32'd1);
        expect_v("alias_nt_tgt", S_TGT0, 32'h100);
        expect_v("alias_nt_tkn", S_TKN0, 32'd1);
        tick();
        upd0(32'h80, 1'b1, 32'h200);
        expect_v("alias_old_hit", S_HIT0, 32'd0);
        expect_v("alias_old_tgt", S_TGT0, 32'd0);
        tick();
        f0 = 32'h80;
        expect_v("alias_new_hit", S_HIT0, 32'd1);
        expect_v("alias_new_tgt", S_TGT0, 32'h200);
        expect_v("alias_new_tkn", S_TKN0, 32'd1);
        tick();

        // Same-cycle read and write
        upd0(32'h40, 1'b1, 32'h100);
        f0 = 32'h40;
        ue0 = 1'b1; up0 = 32'h40; ut0 = 1'b1; utg0 = 32'h300;
        expect_v("rw_old_tgt", S_TGT0, 32'h100);
        expect_v("rw_old_hit", S_HIT0, 32'd1);
        tick();
        ue0 = 1'b0;
        expect_v("rw_new_tgt", S_TGT0, 32'h300);
        expect_v("rw_supd",    S_SU0,  32'd10);
        tick();

        // Mispredict flag without upd_en is not counted
        um0 = 1'b1;
        tick();
        um0 = 1'b0;
        expect_v("mis_gated", S_SM0, 32'd0);
        tick();

        // Reset wins over a same-cycle update
        rst0 = 1'b1;
        ue0 = 1'b1; up0 = 32'h44; ut0 = 1'b1; utg0 = 32'h400; um0 = 1'b1;
        tick();
        rst0 = 1'b0; ue0 = 1'b0; um0 = 1'b0;
        f0 = 32'h44;
        expect_v("rstupd_hit",  S_HIT0, 32'd0);
        expect_v("rstupd_tgt",  S_TGT0, 32'd0);
        expect_v("rstupd_supd", S_SU0,  32'd0);
        expect_v("rstupd_smis", S_SM0,  32'd0);
        tick();
        f0 = 32'h40;
        expect_v("rst_clr_hit", S_HIT0, 32'd0);
        expect_v("rst_clr_tkn", S_TKN0, 32'd0);
        tick();

        // Gshare: history T,T,NT,T -> 1101, three mispredicts
        upd1(32'h1000, 1'b1, 32'h700, 4'h0, 1'b1);
        upd1(32'h1000, 1'b1, 32'h700, 4'h1, 1'b1);
        upd1(32'h1000, 1'b0, 32'h700, 4'h3, 1'b0);
        upd1(32'h1000, 1'b1, 32'h700, 4'h6, 1'b1);
        expect_v("gs_ghr",  S_LG1, 32'hD);
        expect_v("gs_smis", S_SM1, 32'd3);
        expect_v("gs_supd", S_SU1, 32'd4);
        tick();

        // pc 0x40 with history 0011 lands in idx 3; ghr becomes 1011
        upd1(32'h40, 1'b1, 32'h500, 4'h3, 1'b0);
        f1 = 32'h40;
        expect_v("gs_ghr2",     S_LG1,  32'hB);
        expect_v("gs_diff_hit", S_HIT1, 32'd0);
        expect_v("gs_diff_tgt", S_TGT1, 32'd0);
        tick();
        // 0x60 has idx 8, tag 1; 8 ^ 1011 = 3 reaches the same entry
        f1 = 32'h60;
        expect_v("gs_xor_hit", S_HIT1, 32'd1);
        expect_v("gs_xor_tgt", S_TGT1, 32'h500);
        expect_v("gs_xor_tkn", S_TKN1, 32'd1);
        tick();

        // Drain the scoreboard, bounded
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge CLK);
        end
        #1;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer with saturating direction counters, feeding next-PC selection in fetch.
- Replaces the fixed "resolve in MEM, flush on wrong path" branch scheme. Fetch gets a same-cycle taken/target prediction; the MEM stage writes back the resolved outcome.
- Two indexing modes: bimodal (PC only) and gshare (PC XOR global history). Saturating statistics counters support CPU-tracker reporting.

Parameters:
- ENTRIES, 16: BTB depth; power of 2, minimum 2. IDX_W = log2(ENTRIES).
- CNT_W, 2: direction counter width; minimum 2.
- MODE, 0: 0 = bimodal, 1 = gshare.
- GHR_W, 4: global history width; must satisfy GHR_W <= IDX_W; ignored when MODE=0.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- fetch_pc  in  32  PC being fetched (imemaddr).
- pred_hit  out  1  valid BTB entry with matching tag for fetch_pc (combinational).
- pred_taken  out  1  pred_hit AND counter MSB = 1.
- pred_target  out  32  stored target when pred_hit, else 0.
- lookup_ghr  out  GHR_W  history used for this lookup; the pipeline carries it to MEM.
- upd_en  in  1  resolved branch (BEQ/BNE) in MEM, qualified by the pipeline enable.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual branch target.
- upd_ghr  in  GHR_W  lookup_ghr snapshot carried with the branch.
- upd_mispredict  in  1  pipeline detected a wrong prediction (direction or target).
- stat_updates  out  32  count of upd_en cycles, saturating.
- stat_mispredicts  out  32  count of upd_en AND upd_mispredict cycles, saturating.

Behaviour:
- Index and tag:
  - idx = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2].
  - MODE=1: idx is XORed with the history zero-extended to IDX_W. Lookup uses the current ghr; update uses upd_ghr.
- Lookup is purely combinational: no latency, no handshake.
- Read-before-write: a lookup and an update of the same entry in the same cycle returns the pre-update contents. There is no bypass.
- Entry state: valid, tag, target[31:0], cnt[CNT_W-1:0].
- WNT = 2^(CNT_W-1)-1 and WT = 2^(CNT_W-1). For CNT_W=2, WNT=01 and WT=10.
- Update when upd_en=1, by tag match at the update index:
  - Hit, taken: cnt = min(cnt+1, max); target = upd_target.
  - Hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss or invalid, taken: allocate or overwrite the entry; valid=1, tag=upd tag, target=upd_target, cnt=WT.
  - Miss or invalid, not taken: entry unchanged.
- History register (MODE=1 only): on upd_en, ghr = {ghr[GHR_W-2:0], upd_taken}. It is non-speculative and never shifted at fetch. With MODE=0, ghr is held at 0 and lookup_ghr = 0.
- Statistics: both counters saturate at 32'hFFFF_FFFF and never wrap.
- Reset, including when asserted mid-operation:
  - Clears all valid bits, sets every cnt to WNT, clears target and tag to 0.
  - Clears ghr and both statistics counters to 0.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=0, lookup_ghr=0, stat_*=0.
  - RST has priority over upd_en in the same cycle.
- No internal FSM beyond the table, history and counters. With upd_en=0, state holds indefinitely.
- Halt and stall are handled by the datapath gating upd_en. The block has no other enable.

Test Plan:
1. Cold start. RST for 2 cycles, then fetch_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0, stat_updates=0.
2. Allocation (MODE=0). Update pc 0x40, taken, target 0x100 -> next cycle pred_hit=1, pred_taken=1, pred_target=0x100, stat_updates=1.
3. Counter saturation. Three not-taken updates on 0x40 -> cnt 10→01→00→00, and pred_taken=0 after the first. Then two taken updates -> cnt 01 then 10, and pred_taken=1 after the second.
4. Aliasing, checked against the step-2 entry (0x40 at idx 0, tag 1):
   - Update 0x80 (idx 0, tag 2), not taken -> the 0x40 lookup is unchanged.
   - Update 0x80, taken, target 0x200 -> the 0x40 lookup gives pred_hit=0; the 0x80 lookup gives pred_hit=1, target 0x200.
5. Same-cycle read and write. Lookup 0x40 while updating 0x40 taken with target 0x300 -> that cycle shows the old target; the next cycle shows 0x300. Asserting RST together with upd_en -> the entry stays invalid.
6. Gshare (MODE=1, GHR_W=4). Updates taken, taken, not taken, taken -> lookup_ghr=4'b1101. An update of pc 0x40 with upd_ghr=4'b0011 allocates idx 3, so the same pc misses under a different history. Also drive upd_mispredict=1 on 3 updates -> stat_mispredicts=3.
